// File: rtl/seg_tube_driver.sv
// Seven-segment tube driver: hex or double-dabble decimal display of CPU writes,
// scanned over 4 positions that each drive one left-bus and one right-bus digit.

module seg_tube_lane (
  input  logic [3:0][3:0] digits,
  input  logic [3:0]      blank,
  input  logic [1:0]      pos,
  output logic [7:0]      seg
);
  logic [3:0] nib;

  always_comb begin
    nib = digits[pos];
    seg = 8'h00;
    if (!blank[pos]) begin
      case (nib)
        4'h0: seg = 8'hFC;
        4'h1: seg = 8'h60;
        4'h2: seg = 8'hDA;
        4'h3: seg = 8'hF2;
        4'h4: seg = 8'h66;
        4'h5: seg = 8'hB6;
        4'h6: seg = 8'hBE;
        4'h7: seg = 8'hE0;
        4'h8: seg = 8'hFE;
        4'h9: seg = 8'hF6;
        4'hA: seg = 8'hEE;
        4'hB: seg = 8'h3E;
        4'hC: seg = 8'h9C;
        4'hD: seg = 8'h7A;
        4'hE: seg = 8'h9E;
        default: seg = 8'h8E;
      endcase
    end
  end
endmodule

module seg_tube_driver #(
  parameter int SCAN_DIV = 25000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        wr_mode,
  output logic        busy,
  output logic        ovf,
  output logic [7:0]  tubSel,
  output logic [7:0]  tubLeft,
  output logic [7:0]  tubRight
);
  localparam int NUM_LANES = 2;
  localparam int CW        = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t          state;
  logic [31:0]     shreg;
  logic [39:0]     bcd;
  logic [4:0]      cnt;
  logic [7:0][3:0] disp;
  logic [7:0]      bmask;
  logic            dec_mode;

  logic [CW-1:0]   scnt;
  logic [1:0]      pos;

  function automatic logic [39:0] bcd_adj(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Digits 7..1 blank while all digits above and including them are zero.
  function automatic logic [7:0] lz_mask(input logic [31:0] d);
    logic [7:0] m;
    logic       seen;
    m    = '0;
    seen = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (d[4*i +: 4] != 4'd0) seen = 1'b1;
      m[i] = !seen;
    end
    return m;
  endfunction

  logic [39:0] bcd_next;
  logic        ovf_c;
  logic [7:0]  mask_c;

  always_comb begin
    bcd_next = {bcd_adj(bcd)[38:0], shreg[31]};
    ovf_c    = |bcd[39:32];
    mask_c   = (LZ_BLANK && !ovf_c) ? lz_mask(bcd[31:0]) : 8'h00;
  end

  // Hex writes win over everything; a decimal write always (re)starts conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      disp     <= '0;
      bmask    <= '0;
      dec_mode <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else if (wr_en && !wr_mode) begin
      disp     <= wr_data;
      dec_mode <= 1'b0;
      bmask    <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      state    <= IDLE;
    end else if (wr_en && wr_mode) begin
      shreg <= wr_data;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
      state <= CONV;
    end else begin
      case (state)
        CONV: begin
          bcd   <= bcd_next;
          shreg <= {shreg[30:0], 1'b0};
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) state <= COMMIT;
        end
        COMMIT: begin
          disp     <= bcd[31:0];
          dec_mode <= 1'b1;
          ovf      <= ovf_c;
          bmask    <= mask_c;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [NUM_LANES-1:0][7:0] lane_seg;
  logic [7:0]                blank_eff;

  assign blank_eff = dec_mode ? bmask : 8'h00;

  // Lane 0 feeds the right bus (digits 3..0), lane 1 the left bus (digits 7..4).
  for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
    seg_tube_lane u_lane (
      .digits (disp[gl*4 +: 4]),
      .blank  (blank_eff[gl*4 +: 4]),
      .pos    (pos),
      .seg    (lane_seg[gl])
    );
  end

  logic [3:0] oh;
  assign oh = 4'b0001 << pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt     <= '0;
      pos      <= '0;
      tubSel   <= 8'h00;
      tubLeft  <= 8'h00;
      tubRight <= 8'h00;
    end else begin
      if (scnt == CW'(SCAN_DIV - 1)) begin
        scnt <= '0;
        pos  <= pos + 2'd1;
      end else begin
        scnt <= scnt + CW'(1);
      end
      tubSel   <= {oh, oh};
      tubRight <= lane_seg[0];
      tubLeft  <= lane_seg[1];
    end
  end
endmodule

// File: tb/tb_seg_tube_driver.sv
// Directed bench for seg_tube_driver: vector table of writes with expected
// digit segments, plus hand sequences for restart, abort and async reset.

module tb_seg_tube_driver;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_mode;
  logic        busy, ovf;
  logic [7:0]  tubSel, tubLeft, tubRight;

  int pass_cnt = 0;
  int total_cnt = 0;

  seg_tube_driver #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_mode  (wr_mode),
    .busy     (busy),
    .ovf      (ovf),
    .tubSel   (tubSel),
    .tubLeft  (tubLeft),
    .tubRight (tubRight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [31:0] data;
    logic [63:0] segs;  // {digit7 .. digit0}
    logic        ovf;
  } vec_t;

  vec_t vec[10];

  logic watch7 = 1'b0;
  logic seen7  = 1'b0;
  always @(negedge clk)
    if (watch7 && tubSel[0] && tubRight == 8'hE0) seen7 <= 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_write(input logic m, input logic [31:0] d);
    wr_en = 1'b1; wr_mode = m; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_digits(input string name, output logic [63:0] segs);
    logic [3:0] seen;
    logic [3:0] oh;
    seen = '0;
    segs = '0;
    @(posedge clk);
    for (int n = 0; n < 40 && seen != 4'hF; n++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        oh = 4'b0001 << p;
        if (tubSel == {oh, oh}) begin
          segs[8*p +: 8]     = tubRight;
          segs[8*(p+4) +: 8] = tubLeft;
          seen[p] = 1'b1;
        end
      end
    end
    chk({name, "_scan"}, 64'(seen), 64'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] segs;
    logic [3:0]  oh;
    int          n;

    vec[0] = '{1'b0, 32'h1234ABCD, 64'h60DAF266_EE3E9C7A, 1'b0};
    vec[1] = '{1'b0, 32'h89EF0567, 64'hFEF69E8E_FCB6BEE0, 1'b0};
    vec[2] = '{1'b1, 32'd12345,    64'h00000060_DAF266B6, 1'b0};
    vec[3] = '{1'b1, 32'd100000000,64'hFCFCFCFC_FCFCFCFC, 1'b1};
    vec[4] = '{1'b1, 32'hFFFFFFFF, 64'hF666F6BE_E0DAF6B6, 1'b1};
    vec[5] = '{1'b1, 32'd0,        64'h00000000_000000FC, 1'b0};
    vec[6] = '{1'b1, 32'd99999999, 64'hF6F6F6F6_F6F6F6F6, 1'b0};
    vec[7] = '{1'b1, 32'd10,       64'h00000000_000060FC, 1'b0};
    vec[8] = '{1'b0, 32'h00000000, 64'hFCFCFCFC_FCFCFCFC, 1'b0};
    vec[9] = '{1'b1, 32'd1000,     64'h00000000_60FCFCFC, 1'b0};

    rst = 1'b1; wr_en = 1'b0; wr_mode = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {tubSel, tubLeft, tubRight, busy, ovf}, '0);
    rst = 1'b0;

    // Scan order 11,22,44,88 with four cycles per position, all digits "0".
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      oh = 4'b0001 << ((k / 4) % 4);
      chk($sformatf("scan_sel_%0d", k), 64'(tubSel), 64'({oh, oh}));
      chk($sformatf("scan_seg_%0d", k), 64'({tubLeft, tubRight}), 64'h0000_0000_0000_FCFC);
    end

    foreach (vec[i]) begin
      do_write(vec[i].mode, vec[i].data);
      if (vec[i].mode) begin
        count_busy(n);
        chk($sformatf("vec%0d_busy_cycles", i), 64'(n), 64'd33);
      end else begin
        chk($sformatf("vec%0d_busy_hex", i), 64'(busy), 64'd0);
      end
      read_digits($sformatf("vec%0d", i), segs);
      chk($sformatf("vec%0d_segs", i), segs, vec[i].segs);
      chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vec[i].ovf));
    end

    // Decimal 7 overtaken by decimal 42 ten cycles later: 7 must never appear.
    watch7 = 1'b1;
    do_write(1'b1, 32'd7);
    repeat (9) @(negedge clk);
    do_write(1'b1, 32'd42);
    count_busy(n);
    chk("restart_busy_cycles", 64'(n), 64'd33);
    read_digits("restart", segs);
    watch7 = 1'b0;
    chk("restart_segs", segs, 64'h00000000_000066DA);
    chk("restart_never7", 64'(seen7), 64'd0);

    // Hex write aborts an in-flight conversion.
    do_write(1'b1, 32'd12345);
    repeat (5) @(negedge clk);
    do_write(1'b0, 32'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    read_digits("abort", segs);
    chk("abort_segs", segs, 64'hFCFCFCFC_FCFCFCFC);
    repeat (40) @(negedge clk);
    read_digits("abort_late", segs);
    chk("abort_late_segs", segs, 64'hFCFCFCFC_FCFCFCFC);
    chk("abort_late_busy_ovf", 64'({busy, ovf}), 64'd0);

    // Async reset in the middle of a conversion.
    do_write(1'b1, 32'd99999999);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midconv_reset", {tubSel, tubLeft, tubRight, busy, ovf}, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_reset_busy_ovf", 64'({busy, ovf}), 64'd0);
    read_digits("post_reset", segs);
    chk("post_reset_segs", segs, 64'hFCFCFCFC_FCFCFCFC);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/seg_tube_driver.md
Name: seg_tube_driver

Overview:
- Downstream display stage: consumes 32-bit words the CPU writes to the tube I/O address and drives the 8-digit, two-bus seven-segment display.
- Hex mode: the value shows directly.
- Decimal mode: a sequential double-dabble converts the value to BCD, and the display updates only when conversion completes, so the display never flickers.
- The block time-multiplexes 4 scan positions, each driving one left-bus digit and one right-bus digit.

Parameters:
SCAN_DIV, 25000, clk cycles per scan position (must be >= 2)
LZ_BLANK, 1, 1 = blank leading zeros in decimal mode (digit 0 never blanked)

Ports:
clk  in  1  CPU divided clock
rst  in  1  asynchronous active-high reset
wr_en  in  1  one-cycle write strobe from the IO decoder
wr_data  in  32  value to display
wr_mode  in  1  0 = hex, 1 = unsigned decimal; sampled with wr_en
busy  out  1  decimal conversion in progress
ovf  out  1  last committed decimal value > 99_999_999
tubSel  out  8  digit enables, active-high; bit i = digit i, digit 0 rightmost
tubLeft  out  8  segments for digits 7..4, order {a,b,c,d,e,f,g,dp}, active-high
tubRight  out  8  segments for digits 3..0, same order

Behaviour:
- Reset (async, rst=1) drives these values:
  - tubSel=8'h00, tubLeft=tubRight=8'h00, busy=0, ovf=0.
  - Display nibbles = 0, mode = hex, blank mask = 0.
  - Scan counter = 0, scan pos = 0, FSM = IDLE.
- After reset release, all outputs are registered, and the first clk edge drives tubSel=8'h11.
- FSM states:
  - IDLE to CONV when wr_en=1 and wr_mode=1. Load shift reg = wr_data, clear the 40-bit BCD accumulator, step cnt = 0, busy <= 1.
  - CONV: each edge performs one step, first add 3 to every BCD nibble >= 5, then shift {bcd, shift} left by 1, then cnt++. After 32 steps, go to COMMIT.
  - COMMIT: display nibbles <= BCD[31:0], mode = decimal, ovf <= (BCD[39:32] != 0), blank mask computed, busy <= 0. Next state IDLE.
- Decimal latency: wr_en at edge E0, busy high after E0 through E33, display and ovf updated at E33.
- Hex write (wr_en=1, wr_mode=0), in any state:
  - Display nibbles <= wr_data at the same edge.
  - ovf <= 0, blank mask = 0.
  - Any conversion aborts: FSM to IDLE, busy <= 0.
- Decimal write while busy: conversion restarts with the new value; the last write wins. The display keeps the previously committed value until the new commit.
- Leading-zero blanking (LZ_BLANK=1, decimal, ovf=0): digits 7..1 are blanked from the top down while the digit is 0, stopping at the first nonzero digit. Digit 0 always shows. When ovf=1, nothing is blanked, and the low 8 decimal digits show.
- Scanning:
  - Scan counter counts 0..SCAN_DIV-1. On wrap, pos <= pos+1 mod 4.
  - tubSel = (1<<pos) | (1<<(pos+4)).
  - tubRight = seg(digit pos); tubLeft = seg(digit pos+4).
  - A blanked digit drives 8'h00. dp is always 0.
- Segment codes:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0
  - 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E
- Display changes take effect on the tube output registers at the next clk edge after the nibble update.
- Reset during CONV: the conversion is discarded and reset values apply.

Test Plan:
- Reset then release with SCAN_DIV=4:
  - tubSel cycles 11,22,44,88 every 4 cycles.
  - All segments show FC ("0"), since hex mode does not blank.
- Hex write 32'h1234ABCD with wr_mode=0, at pos 0: next edge tubRight=7A ("d"), tubLeft=66 ("4"). busy stays 0.
- Decimal write 32'd12345:
  - busy is high for exactly 33 cycles.
  - After commit: digits 0..4 = B6,66,F2,DA,60, digits 5..7 = 00 (blanked), ovf=0.
- Decimal 32'd100000000: ovf=1, all eight digits FC (no blanking). Decimal 32'hFFFFFFFF: ovf=1, low digits show 94967295.
- Decimal write of 7, then at cycle 10 decimal write of 42:
  - The display never shows 7.
  - busy falls 33 cycles after the second write.
  - Result: digit0=DA, digit1=66.
- Mid-conversion events:
  - Hex write 0 during CONV: busy drops the next edge and the display shows hex 0.
  - Separately, assert rst mid-CONV: outputs are immediately the reset values.
